// File: rtl/ysyx_22040729_lsu.sv
// Load/store unit: one request at a time; partial stores are done as read-modify-write on a 64-bit memory port.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses return resp_err=1 and make no memory access.
module ysyx_22040729_lsu #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned NLANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  wen_q, wen_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  req_ready_d, resp_valid_d, resp_err_d, mem_wen_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  mis_c;

  // Sign/zero extension of the low B/H/W field; D passes through.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [1:0] sz, input logic uns);
    case (sz)
      2'd0:    load_ext = {{(DATA_WIDTH-8){~uns & d[7]}}, d[7:0]};
      2'd1:    load_ext = {{(DATA_WIDTH-16){~uns & d[15]}}, d[15:0]};
      2'd2:    load_ext = {{(DATA_WIDTH-32){~uns & d[31]}}, d[31:0]};
      default: load_ext = d;
    endcase
  endfunction

  // Replace the low (1<<sz) byte lanes of the old word with store data.
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                   input logic [DATA_WIDTH-1:0] new_w,
                                                   input logic [1:0] sz);
    logic [3:0] n;
    n = 4'd1 << sz;
    for (int i = 0; i < NLANES; i++) begin
      merge[8*i +: 8] = (4'(i) < n) ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic [2:0] amask_c;
  assign amask_c = 3'((4'd1 << req_size) - 4'd1);
  assign mis_c   = |(req_addr[2:0] & amask_c);
`else
  assign mis_c   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    wen_d        = wen_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_wen_d    = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = resp_valid;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (mis_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (req_wen && req_size == 2'd3) begin
            state_d     = WRITE;
            mem_wen_d   = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = READ;
            mem_addr_d = req_addr;
          end
        end
      end
      READ: begin
        if (wen_q) begin
          state_d     = WRITE;
          mem_wen_d   = 1'b1;
          mem_wdata_d = merge(mem_rdata, wdata_q, size_q);
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext(mem_rdata, size_q, uns_q);
          resp_err_d   = 1'b0;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      mem_wen    <= mem_wen_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040729_lsu.sv
// Bench for ysyx_22040729_lsu: byte-addressed memory model, byte-level reference model and response scoreboard.
module tb_ysyx_22040729_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  ysyx_22040729_lsu #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  // Memory seen by the DUT; written only by this block
  logic [7:0] mem [0:65535];
  int         mem_gen = 0;
  int         wen_cnt = 0;
  logic       init_done = 1'b0;
  always @(posedge clk) begin
    if (rst && !init_done) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_byte(a);
      init_done <= 1'b1;
      mem_gen   <= mem_gen + 1;
    end else if (mem_wen) begin
      for (int i = 0; i < 8; i++) mem[16'(mem_addr + 16'(i))] <= mem_wdata[8*i +: 8];
      wen_cnt <= wen_cnt + 1;
      mem_gen <= mem_gen + 1;
    end
  end

  always @(mem_addr or mem_gen) begin
    for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[16'(mem_addr + 16'(i))];
  end

  // Reference memory: byte semantics of each access
  logic [7:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          exp_pulse_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  function automatic logic [63:0] model_load(input logic [15:0] a, input logic [1:0] sz, input logic uns);
    logic [63:0] v;
    int          nb;
    nb = 1 << sz;
    v  = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[16'(a + 16'(i))];
    if (!uns && nb < 8 && v[8*nb-1]) begin
      for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic model_mis(input logic [15:0] a, input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
    return (int'(a) % (1 << sz)) != 0;
`else
    return 1'b0 && (a[0] ^ sz[0]);
`endif
  endfunction

  task automatic do_req(input logic wen, input logic [1:0] sz, input logic uns,
                        input logic [15:0] a, input logic [63:0] wd, input int hold);
    logic        mis;
    int          lat, start_cnt, elat, epulse;
    logic [63:0] erd, held;
    logic        eerr;
    mis = model_mis(a, sz);
    if (mis) begin
      exp_rdata_q.push_back(64'd0); exp_err_q.push_back(1'b1);
      exp_lat_q.push_back(1);       exp_pulse_q.push_back(0);
    end else if (wen) begin
      for (int i = 0; i < (1 << sz); i++) ref_mem[16'(a + 16'(i))] = wd[8*i +: 8];
      exp_rdata_q.push_back(64'd0); exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(sz == 2'd3 ? 2 : 3); exp_pulse_q.push_back(1);
    end else begin
      exp_rdata_q.push_back(model_load(a, sz, uns)); exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(2); exp_pulse_q.push_back(0);
    end
    @(negedge clk);
    req_wen = wen; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    start_cnt = wen_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    erd = exp_rdata_q.pop_front(); eerr = exp_err_q.pop_front();
    elat = exp_lat_q.pop_front();  epulse = exp_pulse_q.pop_front();
    check("latency", 64'(lat), 64'(elat));
    check("rdata", resp_rdata, erd);
    check("err", 64'(resp_err), 64'(eerr));
    held = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", resp_rdata, held);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("wen_pulses", 64'(wen_cnt - start_cnt), 64'(epulse));
    check("idle_ready", 64'(req_ready), 64'd1);
    check("idle_valid", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ref_mem[a] = init_byte(a);
    ref_mem[16'h10] = 8'h80;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Place 0x80 at 0x10 through the DUT, then signed/unsigned byte loads
    do_req(1'b1, 2'd0, 1'b0, 16'h0010, 64'h0000_0000_0000_0080, 0);
    do_req(1'b0, 2'd0, 1'b0, 16'h0010, 64'd0, 0);
    do_req(1'b0, 2'd0, 1'b1, 16'h0010, 64'd0, 0);

    // Halfword RMW inside a dword
    do_req(1'b1, 2'd3, 1'b0, 16'h0010, 64'h1122_3344_5566_7788, 0);
    do_req(1'b1, 2'd1, 1'b0, 16'h0012, 64'h0000_0000_0000_BEEF, 0);
    do_req(1'b0, 2'd3, 1'b0, 16'h0010, 64'd0, 0);

    // Full dword store skips the read
    do_req(1'b1, 2'd3, 1'b0, 16'h0020, 64'hDEAD_BEEF_CAFE_F00D, 0);
    do_req(1'b0, 2'd3, 1'b1, 16'h0020, 64'd0, 0);

    // Backpressure on the response
    do_req(1'b0, 2'd2, 1'b0, 16'h0020, 64'd0, 3);

    // Misaligned word, halfword and wrap at the top of the address space
    do_req(1'b0, 2'd2, 1'b0, 16'h0011, 64'd0, 0);
    do_req(1'b1, 2'd1, 1'b0, 16'hFFFF, 64'h0000_0000_0000_A55A, 0);
    do_req(1'b0, 2'd1, 1'b1, 16'hFFFF, 64'd0, 0);
    do_req(1'b0, 2'd2, 1'b0, 16'h0004, 64'd0, 0);
    do_req(1'b0, 2'd1, 1'b0, 16'h0022, 64'd0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  sz;
      logic [15:0] a;
      sz = 2'($urandom_range(0, 3));
      a  = 16'($urandom_range(16'h40, 16'h5F));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             {$urandom, $urandom}, 0);
    end

    // Reset in the WRITE cycle of a byte store: memory must stay untouched
    @(negedge clk);
    req_wen = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 16'h0030;
    req_wdata = 64'h5A; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("write_wen", 64'(mem_wen), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_wen", 64'(mem_wen), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_valid", 64'(resp_valid), 64'd0);
    do_req(1'b0, 2'd0, 1'b1, 16'h0030, 64'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
